// File: rtl/udiv_pkg.sv
// Shared widths, iteration count and FSM state type for the 16-by-8 sequential divider.
package udiv_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int REM_W      = DIVISOR_W + 1;
  localparam int ITER_COUNT = DIVIDEND_W;
  localparam int CNT_W      = $clog2(ITER_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } udiv_state_e;

endpackage

// File: rtl/udiv_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module udiv_step
  import udiv_pkg::*;
(
  input  logic [REM_W-1:0]     rem,
  input  logic                 dividend_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [REM_W-1:0]     rem_next,
  output logic                 q_bit
);

  localparam int TRIAL_W = REM_W + 1;

  logic [TRIAL_W-1:0] trial;
  logic [TRIAL_W-1:0] divisor_ext;

  always_comb begin
    trial       = {rem, dividend_bit};
    divisor_ext = {{(TRIAL_W - DIVISOR_W){1'b0}}, divisor};
    q_bit       = (trial >= divisor_ext);
    // Partial remainder stays below the divisor, so the top trial bit never survives truncation
    rem_next    = q_bit ? REM_W'(trial - divisor_ext) : REM_W'(trial);
  end

endmodule

// File: rtl/unsigned_divider_16by8_seq.sv
// Sequential 16-by-8 unsigned restoring divider with valid/ready handshakes on both sides.
// Define UDIV_APPROX_EN to skip the low LSB_CUT quotient bits (remainder then reads as zero).
module unsigned_divider_16by8_seq
  import udiv_pkg::*;
#(
  parameter int LSB_CUT = 6
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] x,
  input  logic [DIVISOR_W-1:0]  y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] q,
  output logic [DIVISOR_W-1:0]  r,
  output logic                  dz
);

  if (LSB_CUT < 0 || LSB_CUT > 8) begin : g_bad_cut
    $error("LSB_CUT must lie in 0..8");
  end

`ifdef UDIV_APPROX_EN
  localparam int CUT = LSB_CUT;
`else
  localparam int CUT = 0;
`endif

  localparam logic [CNT_W-1:0] N_ITER = CNT_W'(ITER_COUNT - CUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  udiv_state_e state;
  udiv_state_e state_next;

  logic [DIVIDEND_W-1:0] work;
  logic [DIVISOR_W-1:0]  divisor_r;
  logic [REM_W-1:0]      rem_r;
  logic [CNT_W-1:0]      count;
  logic [DIVIDEND_W-1:0] q_r;
  logic [DIVISOR_W-1:0]  r_r;
  logic                  dz_r;

  logic [REM_W-1:0]      rem_step;
  logic                  q_bit;
  logic [DIVIDEND_W-1:0] work_next;
  logic [DIVIDEND_W-1:0] q_final;
  logic [DIVISOR_W-1:0]  r_final;
  logic                  handshake;
  logic                  last_step;

  udiv_step u_step (
    .rem          (rem_r),
    .dividend_bit (work[DIVIDEND_W-1]),
    .divisor      (divisor_r),
    .rem_next     (rem_step),
    .q_bit        (q_bit)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign handshake = in_valid && in_ready;
  assign last_step = (state == BUSY) && (count == ONE);

  // Dividend bits leave at the top while quotient bits enter at the bottom of the same register
  assign work_next = {work[DIVIDEND_W-2:0], q_bit};

`ifdef UDIV_APPROX_EN
  assign q_final = work_next << CUT;
  assign r_final = '0;
`else
  assign q_final = work_next;
  assign r_final = rem_step[DIVISOR_W-1:0];
`endif

  assign q  = q_r;
  assign r  = r_r;
  assign dz = dz_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_next = (y == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (count == ONE) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= '0;
      divisor_r <= '0;
      rem_r     <= '0;
      count     <= '0;
      q_r       <= '0;
      r_r       <= '0;
      dz_r      <= 1'b0;
    end else if (handshake) begin
      if (y == '0) begin
        q_r  <= '1;
        r_r  <= x[DIVISOR_W-1:0];
        dz_r <= 1'b1;
      end else begin
        work      <= x;
        divisor_r <= y;
        rem_r     <= '0;
        count     <= N_ITER;
      end
    end else if (state == BUSY) begin
      work  <= work_next;
      rem_r <= rem_step;
      count <= count - ONE;
      if (last_step) begin
        q_r  <= q_final;
        r_r  <= r_final;
        dz_r <= 1'b0;
      end
    end
  end

endmodule

// File: doc/unsigned_divider_16by8_seq.md
UNSIGNED_DIVIDER_16BY8_SEQ -- requirements
Module: unsigned_divider_16by8_seq

Interface
REQ-001 SHALL have parameter LSB_CUT, default 6, number of low quotient bits skipped when the approximate mode is compiled in (legal 0..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port x  input  16  unsigned dividend.
REQ-007 SHALL have port y  input  8  unsigned divisor.
REQ-008 SHALL have port out_valid  output  1  result held on q/r/dz.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port q  output  16  unsigned quotient.
REQ-011 SHALL have port r  output  8  unsigned remainder.
REQ-012 SHALL have port dz  output  1  divide-by-zero flag.

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; an input handshake is in_valid&&in_ready.
REQ-015 SHALL, on a handshake with y!=0, capture x and y, clear the partial remainder (9 bits), set the iteration count to 16, and enter BUSY.
REQ-016 SHALL, each BUSY cycle, perform one restoring step: shift {rem, next dividend MSB}, subtract y when the result is >=y, and shift the resulting quotient bit in at the LSB.
REQ-017 SHALL leave BUSY for DONE after the final step; out_valid rises 16 cycles after the handshake cycle.
REQ-018 SHALL, on a handshake with y==0, go directly to DONE with q=16'hFFFF, r=x[7:0] and dz=1; out_valid rises 1 cycle after the handshake.
REQ-019 SHALL drive out_valid=1 only in DONE and hold q, r and dz stable while out_valid&&!out_ready.
REQ-020 SHALL return to IDLE on out_valid&&out_ready; in_ready rises the following cycle (no same-cycle accept/issue overlap).
REQ-021 SHALL ignore in_valid while in BUSY or DONE; operands on x and y are sampled only at the handshake.
REQ-022 SHALL satisfy x == q*y + r with r<y for every y!=0 in exact mode.
REQ-023 SHALL drive dz=0 for every y!=0.

Reset
REQ-024 SHALL, while rst_n=0, force state=IDLE, out_valid=0, q=0, r=0, dz=0 and the iteration count to 0, regardless of clk.
REQ-025 SHALL discard any in-flight division when reset is asserted mid-BUSY or mid-DONE; no out_valid follows deassertion.
REQ-026 SHALL present in_ready=1 on the first clock edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with macro UDIV_APPROX_EN defined, run only 16-LSB_CUT iterations, force q[LSB_CUT-1:0]=0 and r=0; out_valid rises 16-LSB_CUT cycles after the handshake.
REQ-028 SHALL, without UDIV_APPROX_EN, behave exactly per REQ-015..REQ-023 and leave LSB_CUT unused.
REQ-029 SHALL keep divide-by-zero behaviour (REQ-018) identical in both builds.

Structure
REQ-030 SHALL take the state enum, the widths (DIVIDEND_W=16, DIVISOR_W=8) and the iteration count constant from shared package udiv_pkg.
REQ-031 SHALL isolate one restoring step as combinational sub-module udiv_step (inputs: remainder, dividend bit, divisor; outputs: next remainder, quotient bit).

Verification
REQ-032 SHALL cover: x=1000, y=7 -> q=142, r=6, dz=0, out_valid 16 cycles after the handshake.
REQ-033 SHALL cover: x=16'hFFFF, y=8'hFF -> q=257, r=0, dz=0.
REQ-034 SHALL cover: x=16'h04D2, y=0 -> q=16'hFFFF, r=8'hD2, dz=1, out_valid after 1 cycle.
REQ-035 SHALL cover: result ready with out_ready=0 for 5 cycles -> q/r/dz/out_valid stable, in_ready=0 throughout; in_valid pulses during BUSY ignored.
REQ-036 SHALL cover: rst_n pulsed low 5 cycles into BUSY -> outputs immediately 0, in_ready=1 after release, no spurious out_valid.
REQ-037 SHALL cover (UDIV_APPROX_EN, LSB_CUT=6): x=1000, y=7 -> q=128, r=0, out_valid after 10 cycles.
